// File: rtl/dift_trap_ctrl.sv
// DIFT tag-check trap receiver: turns the tag check unit's single-cycle trap
// pulse into a held exception request, captures cause/PC for software,
// counts violations (saturating) and flags traps that arrive while a cause
// is still held.
module dift_trap_ctrl #(
  parameter int TRAP_TYPE_W = 3,
  parameter int CNT_W       = 16,
  parameter int PC_W        = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable_i,
  input  logic                   trap_i,
  input  logic [TRAP_TYPE_W-1:0] trap_type_i,
  input  logic [PC_W-1:0]        pc_i,
  input  logic                   ctrl_ack_i,
  input  logic                   clr_i,
  output logic                   trap_req_o,
  output logic                   halt_o,
  output logic                   cause_valid_o,
  output logic [TRAP_TYPE_W-1:0] cause_type_o,
  output logic [PC_W-1:0]        cause_pc_o,
  output logic                   overflow_o,
  output logic [CNT_W-1:0]       trap_cnt_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] HELD = 2'd2;

  logic [1:0]       state;
  logic             trap_seen;
  logic [CNT_W-1:0] cnt_inc;

  // Qualified trap and saturating increment value
  always_comb begin
    trap_seen = enable_i & trap_i;
    cnt_inc   = (trap_cnt_o == '1) ? trap_cnt_o : trap_cnt_o + 1'b1;
  end

  // Trap FSM with registered request, cause capture, overflow and counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      trap_req_o    <= 1'b0;
      halt_o        <= 1'b0;
      cause_valid_o <= 1'b0;
      cause_type_o  <= '0;
      cause_pc_o    <= '0;
      overflow_o    <= 1'b0;
      trap_cnt_o    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (trap_seen) begin
            state         <= REQ;
            trap_req_o    <= 1'b1;
            halt_o        <= 1'b1;
            cause_valid_o <= 1'b1;
            cause_type_o  <= trap_type_i;
            cause_pc_o    <= pc_i;
            trap_cnt_o    <= cnt_inc;
          end
        end
        REQ: begin
          // Traps and clears are ignored until the controller acknowledges
          if (ctrl_ack_i) begin
            state      <= HELD;
            trap_req_o <= 1'b0;
            halt_o     <= 1'b0;
          end
        end
        HELD: begin
          if (trap_seen && clr_i) begin
            state         <= REQ;
            trap_req_o    <= 1'b1;
            halt_o        <= 1'b1;
            cause_valid_o <= 1'b1;
            cause_type_o  <= trap_type_i;
            cause_pc_o    <= pc_i;
            overflow_o    <= 1'b0;
            trap_cnt_o    <= cnt_inc;
          end else if (trap_seen) begin
            overflow_o <= 1'b1;
            trap_cnt_o <= cnt_inc;
          end else if (clr_i) begin
            state         <= IDLE;
            cause_valid_o <= 1'b0;
            overflow_o    <= 1'b0;
          end
        end
        default: begin
          state         <= IDLE;
          trap_req_o    <= 1'b0;
          halt_o        <= 1'b0;
          cause_valid_o <= 1'b0;
          overflow_o    <= 1'b0;
        end
      endcase
    end
  end

endmodule
